// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, digit width, digit moduli and the digit increment helper
package stopwatch_pkg;
    localparam int DIGIT_W   = 4;
    localparam int MOD_UNITS = 10;
    localparam int MOD_TENS  = 6;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    // Value a mod-m digit takes after an edge with enable e; wraps m-1 -> 0
    function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] d, input int m, input logic e);
        return !e ? d : (d == DIGIT_W'(m - 1)) ? '0 : d + DIGIT_W'(1);
    endfunction
endpackage

// File: rtl/stopwatch_up_if.sv
// stopwatch_up_if: control strobes in, BCD display digits and status flags out
interface stopwatch_up_if;
    import stopwatch_pkg::*;
    logic               tick;
    logic               start_stop;
    logic               lap;
    logic [DIGIT_W-1:0] sec_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] min_tens;
    logic               running;
    logic               lapped;
    logic               at_max;
    logic               wrapped;

    modport master (
        output tick, start_stop, lap,
        input  sec_ones, sec_tens, min_ones, min_tens, running, lapped, at_max, wrapped
    );
    modport slave (
        input  tick, start_stop, lap,
        output sec_ones, sec_tens, min_ones, min_tens, running, lapped, at_max, wrapped
    );
endinterface

// File: rtl/stopwatch_up_counter.sv
// counter_up_mod: one mod-MOD up-counting BCD digit with carry-out for the ripple chain
module counter_up_mod
    import stopwatch_pkg::*;
#(
    parameter int MOD = MOD_UNITS
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               en,
    output logic [DIGIT_W-1:0] count,
    output logic               tc
);
    assign tc = en && count == DIGIT_W'(MOD - 1);

    // Digit register: wraps MOD-1 -> 0 when enabled
    always_ff @(posedge clk) begin
        if (clear) count <= '0;
        else       count <= next_digit(count, MOD, en);
    end
endmodule

// File: rtl/stopwatch_up.sv
// stopwatch_up: MM:SS up-counting stopwatch with run/pause/done FSM and lap display freeze
module stopwatch_up
    import stopwatch_pkg::*;
#(
    parameter bit STOP_AT_MAX = 1'b1
) (
    input  logic           clk,
    input  logic           clear,
    stopwatch_up_if.slave  sw
);
    state_t               state;
    logic [DIGIT_W-1:0]   so, st, mo, mt;
    logic                 c0, c1, c2, c3;
    logic                 en, at_max_i, go_done, lapped_n;
    logic                 running_q, lapped_q, wrapped_q;
    logic [4*DIGIT_W-1:0] disp, count_n;

    assign at_max_i = so == 4'd9 && st == 4'd5 && mo == 4'd9 && mt == 4'd5;
    assign go_done  = STOP_AT_MAX && state == RUN && sw.tick && at_max_i;
    assign en       = sw.tick && state == RUN && !go_done;

    counter_up_mod #(.MOD(MOD_UNITS)) u_so (.clk(clk), .clear(clear), .en(en), .count(so), .tc(c0));
    counter_up_mod #(.MOD(MOD_TENS))  u_st (.clk(clk), .clear(clear), .en(c0), .count(st), .tc(c1));
    counter_up_mod #(.MOD(MOD_UNITS)) u_mo (.clk(clk), .clear(clear), .en(c1), .count(mo), .tc(c2));
    counter_up_mod #(.MOD(MOD_TENS))  u_mt (.clk(clk), .clear(clear), .en(c2), .count(mt), .tc(c3));

    // The count as it will be after this edge, so the display and lap capture show that edge's increment
    assign count_n = {next_digit(mt, MOD_TENS, c2), next_digit(mo, MOD_UNITS, c1),
                      next_digit(st, MOD_TENS, c0), next_digit(so, MOD_UNITS, en)};

    // Lap toggles only in RUN/PAUSE; entering DONE or leaving those states drops the freeze
    always_comb begin
        lapped_n = ((state == RUN || state == PAUSE) && !go_done) ? lapped_q ^ sw.lap : 1'b0;
    end

    // Control FSM with registered status flags and the display/lap snapshot register
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            running_q <= 1'b0;
            lapped_q  <= 1'b0;
            wrapped_q <= 1'b0;
            disp      <= '0;
        end else begin
            lapped_q  <= lapped_n;
            wrapped_q <= c3;
            disp      <= (lapped_q && lapped_n) ? disp : count_n;
            case (state)
                IDLE: if (sw.start_stop) begin
                    state     <= RUN;
                    running_q <= 1'b1;
                end
                RUN: if (go_done) begin
                    state     <= DONE;
                    running_q <= 1'b0;
                end else if (sw.start_stop) begin
                    state     <= PAUSE;
                    running_q <= 1'b0;
                end
                PAUSE: if (sw.start_stop) begin
                    state     <= RUN;
                    running_q <= 1'b1;
                end
                default: state <= DONE;
            endcase
        end
    end

    assign {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones} = disp;
    assign sw.running = running_q;
    assign sw.lapped  = lapped_q;
    assign sw.wrapped = wrapped_q;
    assign sw.at_max  = at_max_i;
endmodule

// File: tb/tb_stopwatch_up.sv
// tb_stopwatch_up: scoreboard bench driving STOP_AT_MAX=1 and STOP_AT_MAX=0 instances in lockstep
module tb_stopwatch_up;
    typedef struct {
        int          cyc;
        string       name;
        logic [19:0] e1;
        logic [19:0] e0;
    } exp_t;

    logic clk = 1'b0;
    logic clear = 1'b0, tick = 1'b0, ss = 1'b0, lap = 1'b0;
    int   cyc = 0, n_tests = 0, n_fail = 0;
    bit   stim_done = 1'b0;
    exp_t q[$];

    stopwatch_up_if i1 ();
    stopwatch_up_if i0 ();

    assign {i1.tick, i1.start_stop, i1.lap} = {tick, ss, lap};
    assign {i0.tick, i0.start_stop, i0.lap} = {tick, ss, lap};

    stopwatch_up #(.STOP_AT_MAX(1'b1)) dut1 (.clk(clk), .clear(clear), .sw(i1));
    stopwatch_up #(.STOP_AT_MAX(1'b0)) dut0 (.clk(clk), .clear(clear), .sw(i0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {MM:SS as BCD, running, lapped, at_max, wrapped}
    function automatic logic [19:0] pk(input logic [15:0] d, input logic r, input logic l, input logic a, input logic w);
        return {d, r, l, a, w};
    endfunction

    task automatic step(input logic c, input logic s, input logic t, input logic l);
        {clear, ss, tick, lap} = {c, s, t, l};
        @(posedge clk);
        #1;
        {clear, ss, tick, lap} = 4'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic expect2(input string name, input logic [19:0] e1, input logic [19:0] e0);
        exp_t e;
        e.cyc = cyc; e.name = name; e.e1 = e1; e.e0 = e0;
        q.push_back(e);
    endtask

    task automatic expect_both(input string name, input logic [19:0] e);
        expect2(name, e, e);
    endtask

    // Monitor: compares both instances against the queued expectation due this cycle
    initial begin
        logic [19:0] a1, a0;
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e  = q.pop_front();
                a1 = {i1.min_tens, i1.min_ones, i1.sec_tens, i1.sec_ones, i1.running, i1.lapped, i1.at_max, i1.wrapped};
                a0 = {i0.min_tens, i0.min_ones, i0.sec_tens, i0.sec_ones, i0.running, i0.lapped, i0.at_max, i0.wrapped};
                n_tests += 2;
                if (a1 !== e.e1) begin
                    n_fail++;
                    $display("FAIL %s [max=1]: got %h exp %h", e.name, a1, e.e1);
                end
                if (a0 !== e.e0) begin
                    n_fail++;
                    $display("FAIL %s [max=0]: got %h exp %h", e.name, a0, e.e0);
                end
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_both("reset", pk(16'h0000, 0, 0, 0, 0));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        expect_both("count_10", pk(16'h0010, 1, 0, 0, 0));

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(59);
        expect_both("sec_carry_59", pk(16'h0059, 1, 0, 0, 0));
        ticks(1);
        expect_both("sec_carry_100", pk(16'h0100, 1, 0, 0, 0));
        ticks(540);
        expect_both("min_carry_1000", pk(16'h1000, 1, 0, 0, 0));
        ticks(2999);
        expect_both("at_5959", pk(16'h5959, 1, 0, 1, 0));
        ticks(1);
        expect2("max_tick", pk(16'h5959, 0, 0, 1, 0), pk(16'h0000, 1, 0, 0, 1));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        expect2("wrap_pulse_end", pk(16'h5959, 0, 0, 1, 0), pk(16'h0000, 1, 0, 0, 0));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect2("done_ignores_ss", pk(16'h5959, 0, 0, 1, 0), pk(16'h0000, 0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        expect2("done_ignores_lap", pk(16'h5959, 0, 0, 1, 0), pk(16'h0000, 0, 1, 0, 0));
        ticks(2);
        expect2("done_ignores_tick", pk(16'h5959, 0, 0, 1, 0), pk(16'h0000, 0, 1, 0, 0));

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        expect_both("lap_on", pk(16'h0005, 1, 1, 0, 0));
        ticks(7);
        expect_both("lap_frozen", pk(16'h0005, 1, 1, 0, 0));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        expect_both("lap_off", pk(16'h0012, 1, 0, 0, 0));
        step(1'b0, 1'b0, 1'b1, 1'b1);
        expect_both("lap_with_tick", pk(16'h0013, 1, 1, 0, 0));
        step(1'b0, 1'b0, 1'b0, 1'b1);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        expect_both("ss_with_tick", pk(16'h0004, 0, 0, 0, 0));
        ticks(3);
        expect_both("pause_hold", pk(16'h0004, 0, 0, 0, 0));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        expect_both("resume", pk(16'h0005, 1, 0, 0, 0));

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(754);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        expect_both("lap_1234", pk(16'h1234, 1, 1, 0, 0));
        ticks(1);
        expect_both("lap_1234_hold", pk(16'h1234, 1, 1, 0, 0));
        step(1'b1, 1'b1, 1'b1, 1'b0);
        expect_both("clear_priority", pk(16'h0000, 0, 0, 0, 0));
        ticks(2);
        expect_both("idle_ignores_tick", pk(16'h0000, 0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        expect_both("idle_ignores_lap", pk(16'h0000, 0, 0, 0, 0));
        stim_done = 1'b1;
    end

    initial begin
        int budget = 20000;
        while (!stim_done && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (!stim_done) begin
            n_tests++; n_fail++;
            $display("FAIL stimulus_timeout: got running exp finished");
        end
        repeat (3) @(posedge clk);
        while (q.size() > 0) begin
            exp_t e = q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL %s: got unchecked exp checked", e.name);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
